// File: rtl/scope_fb_scheduler_pkg.sv
// Shared types and default geometry for the oscilloscope frame-buffer scheduler.
package scope_fb_scheduler_pkg;

  localparam int DEF_H_RES      = 640;
  localparam int DEF_V_RES      = 480;
  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_ADC_BITS   = 12;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_PLOT  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/scope_fb_scheduler_adc_row_scale.sv
// Registered ADC-sample to pixel-address converter: row = V_RES-1 - (sample*V_RES >> ADC_BITS),
// addr = row*H_RES + col, captured on en (one cycle latency).
module adc_row_scale
  import scope_fb_scheduler_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ADC_BITS   = DEF_ADC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADC_BITS-1:0]   smp_data,
  input  logic [ADDR_WIDTH-1:0] col,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int PW = ADC_BITS + 11;

  logic [PW-1:0]         prod;
  logic [PW-1:0]         scaled;
  logic [ADDR_WIDTH-1:0] row;

  // Full-scale sample maps to the top row, zero to the bottom row.
  always_comb begin
    prod   = PW'(smp_data) * PW'(V_RES);
    scaled = prod >> ADC_BITS;
    row    = ADDR_WIDTH'(V_RES - 1) - ADDR_WIDTH'(scaled);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (en) begin
      addr <= row * ADDR_WIDTH'(H_RES) + col;
    end
  end

endmodule

// File: rtl/scope_fb_scheduler.sv
// Ping-pong frame-buffer scheduler: clears the draw BRAM, plots one sample per column,
// then swaps draw/display roles on a vsync rising edge.
module scope_fb_scheduler
  import scope_fb_scheduler_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ADC_BITS   = DEF_ADC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic [ADC_BITS-1:0]   smp_data,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic                  we0,
  output logic                  we1,
  output logic                  wd,
  output logic                  disp_sel,
  output logic                  frame_ready,
  output logic [15:0]           overrun_cnt,
  output state_t                dbg_state
);

  // Sample handshake: a sample transfers on a clock edge where smp_valid and smp_ready
  // are both high; the source holds smp_data stable while smp_valid is high without ready.

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(H_RES * V_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(H_RES - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] plot_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_plot;
  logic                  vs_q;
  logic                  vs_edge;
  logic                  hs;
  logic                  wr_issue;

  assign vs_edge   = vsync & ~vs_q;
  assign hs        = smp_valid & smp_ready;
  assign wr_issue  = (state == S_CLEAR) | hs;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CLEAR: if (counter == LAST_PIX)       state_n = S_PLOT;
      S_PLOT:  if (hs && (col == LAST_COL))   state_n = S_DONE;
      S_DONE:  if (vs_edge)                   state_n = S_CLEAR;
      default:                                state_n = S_CLEAR;
    endcase
  end

  adc_row_scale #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADC_BITS   (ADC_BITS)
  ) u_scale (
    .clk      (clk),
    .rst      (rst),
    .en       (hs),
    .smp_data (smp_data),
    .col      (col),
    .addr     (plot_addr)
  );

  // disp_sel=1 means BRAM0 is the draw buffer; writes are never in flight across a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter     <= '0;
      col         <= '0;
      clr_addr    <= '0;
      wr_plot     <= 1'b0;
      vs_q        <= 1'b0;
      disp_sel    <= 1'b1;
      we0         <= 1'b0;
      we1         <= 1'b0;
      wd          <= 1'b0;
      smp_ready   <= 1'b0;
      frame_ready <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      vs_q        <= vsync;
      we0         <= wr_issue & disp_sel;
      we1         <= wr_issue & ~disp_sel;
      wd          <= hs;
      wr_plot     <= hs;
      smp_ready   <= (state_n == S_PLOT);
      frame_ready <= (state_n == S_DONE);
      if (state == S_CLEAR) begin
        clr_addr <= counter;
        counter  <= counter + 1'b1;
      end
      if ((state == S_CLEAR) && (state_n == S_PLOT)) col <= '0;
      if (hs) col <= col + 1'b1;
      if ((state == S_DONE) && vs_edge) begin
        disp_sel <= ~disp_sel;
        counter  <= '0;
      end
      if (vs_edge && (state != S_DONE) && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  assign wr_addr = wr_plot ? plot_addr : clr_addr;
  assign addr0   = disp_sel ? wr_addr : rd_addr;
  assign addr1   = disp_sel ? rd_addr : wr_addr;

endmodule
